// File: rtl/matvec_param_engine.sv
// matvec_param_engine: skewed ROWS-stage MAC chain computing C=A*B from per-row A FIFOs and a shared B FIFO
module matvec_param_engine #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH = 2*DATA_WIDTH+$clog2(COLS)
) (
  input  logic                       CLOCK_50,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [ROWS-1:0]            a_wren,
  input  logic [ROWS*DATA_WIDTH-1:0] a_data,
  input  logic                       b_wren,
  input  logic [DATA_WIDTH-1:0]      b_data,
  output logic [ROWS-1:0]            a_full,
  output logic                       b_full,
  output logic                       busy,
  output logic                       done,
  output logic [ROWS*ACC_WIDTH-1:0]  c_data,
  output logic [2:0]                 dbg_state
);
  localparam int PW = $clog2(COLS);
  localparam int CW = $clog2(COLS+ROWS)+1;
  typedef enum logic [2:0] {IDLE, CLR, EXEC, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic sm, load, go;
  logic [ROWS-1:0] en, clr;
  logic [ROWS-2:0] en_q, clr_q;
  logic [DATA_WIDTH-1:0] b_s [ROWS];
  logic [DATA_WIDTH-1:0] b_q [ROWS-1];
  logic [DATA_WIDTH-1:0] b_mem [COLS];
  logic [PW-1:0] b_wp, b_rp;
  logic [PW:0] b_cnt;
  assign load = state == IDLE || state == DONE;
  assign go = load && start && &a_full && b_full;
  assign busy = state == CLR || state == EXEC || state == DRAIN;
  assign done = state == DONE;
  assign dbg_state = state;
  assign b_full = b_cnt == (PW+1)'(COLS);
  assign en = {en_q, state == EXEC};
  assign clr = {clr_q, state == CLR};
  always_comb begin
    state_nx = go ? CLR :
               state == CLR ? EXEC :
               state == EXEC && cnt == CW'(COLS-1) ? DRAIN :
               state == DRAIN && cnt == CW'(COLS+ROWS-2) ? DONE : state;
  end
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      sm <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == EXEC || state == DRAIN ? cnt + 1'b1 : '0;
      if (go) sm <= signed_mode;
    end
  end
  always_comb begin
    b_s[0] = b_mem[b_rp];
    for (int i = 1; i < ROWS; i++) b_s[i] = b_q[i-1];
  end
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
      clr_q <= '0;
      for (int i = 0; i < ROWS-1; i++) b_q[i] <= '0;
    end else begin
      en_q <= en[ROWS-2:0];
      clr_q <= clr[ROWS-2:0];
      for (int i = 0; i < ROWS-1; i++) b_q[i] <= b_s[i];
    end
  end
  always_ff @(posedge CLOCK_50)
    if (load && b_wren && !b_full) b_mem[b_wp] <= b_data;
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      b_wp <= '0;
      b_rp <= '0;
      b_cnt <= '0;
    end else begin
      if (load && b_wren && !b_full) begin
        b_wp <= b_wp == PW'(COLS-1) ? '0 : b_wp + 1'b1;
        b_cnt <= b_cnt + 1'b1;
      end
      if (en[0]) begin
        b_rp <= b_rp == PW'(COLS-1) ? '0 : b_rp + 1'b1;
        b_cnt <= b_cnt - 1'b1;
      end
    end
  end
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_WIDTH-1:0] mem [COLS];
    logic [PW-1:0] wp, rp;
    logic [PW:0] n;
    logic [DATA_WIDTH-1:0] a;
    logic [2*DATA_WIDTH-1:0] p;
    logic [ACC_WIDTH-1:0] acc;
    logic wr;
    assign wr = load && a_wren[r] && !a_full[r];
    assign a = mem[rp];
    assign p = {{DATA_WIDTH{sm & a[DATA_WIDTH-1]}}, a} *
               {{DATA_WIDTH{sm & b_s[r][DATA_WIDTH-1]}}, b_s[r]};
    assign a_full[r] = n == (PW+1)'(COLS);
    assign c_data[r*ACC_WIDTH +: ACC_WIDTH] = acc;
    always_ff @(posedge CLOCK_50)
      if (wr) mem[wp] <= a_data[r*DATA_WIDTH +: DATA_WIDTH];
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
        wp <= '0;
        rp <= '0;
        n <= '0;
        acc <= '0;
      end else begin
        if (wr) begin
          wp <= wp == PW'(COLS-1) ? '0 : wp + 1'b1;
          n <= n + 1'b1;
        end
        if (en[r]) begin
          rp <= rp == PW'(COLS-1) ? '0 : rp + 1'b1;
          n <= n - 1'b1;
        end
        acc <= clr[r] ? '0 :
               en[r] ? acc + {{(ACC_WIDTH-2*DATA_WIDTH){sm & p[2*DATA_WIDTH-1]}}, p} : acc;
      end
    end
  end
endmodule

// File: tb/tb_matvec_param_engine.sv
// tb_matvec_param_engine: directed self-checking bench for the default and a 4x16x4 configuration
module tb_matvec_param_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, sm = 1'b0, b_wren = 1'b0;
  logic [7:0] a_wren = '0;
  logic [63:0] a_data = '0;
  logic [7:0] b_data = '0;
  logic [7:0] a_full;
  logic b_full, busy, done;
  logic [8*19-1:0] c_data;
  logic [2:0] dbg_state;
  logic start2 = 1'b0, b_wren2 = 1'b0;
  logic [3:0] a_wren2 = '0;
  logic [15:0] a_data2 = '0;
  logic [3:0] b_data2 = '0;
  logic [3:0] a_full2;
  logic b_full2, busy2, done2;
  logic [4*12-1:0] c_data2;
  logic [2:0] dbg_state2;
  logic [7:0] A [8][8];
  logic [7:0] B [8];
  int errors = 0, checks = 0;
  int lat, bc, st1;

  always #5 clk = ~clk;

  matvec_param_engine dut (
    .CLOCK_50(clk), .rst_n(rst_n), .start(start), .signed_mode(sm),
    .a_wren(a_wren), .a_data(a_data), .b_wren(b_wren), .b_data(b_data),
    .a_full(a_full), .b_full(b_full), .busy(busy), .done(done),
    .c_data(c_data), .dbg_state(dbg_state)
  );

  matvec_param_engine #(.ROWS(4), .COLS(16), .DATA_WIDTH(4)) dut2 (
    .CLOCK_50(clk), .rst_n(rst_n), .start(start2), .signed_mode(1'b0),
    .a_wren(a_wren2), .a_data(a_data2), .b_wren(b_wren2), .b_data(b_data2),
    .a_full(a_full2), .b_full(b_full2), .busy(busy2), .done(done2),
    .c_data(c_data2), .dbg_state(dbg_state2)
  );

  task automatic load(input logic do_a, input logic do_b);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a_wren = do_a ? 8'hFF : 8'h00;
      b_wren = do_b;
      for (int r = 0; r < 8; r++) a_data[r*8 +: 8] = A[r][k];
      b_data = B[k];
    end
    @(negedge clk);
    a_wren = '0;
    b_wren = 1'b0;
  endtask

  task automatic run(output int l, output int b, output int s);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = int'(dbg_state);
    l = -1;
    b = 0;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin
        l = k;
        break;
      end
      if (busy) b++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", dbg_state); end
    checks++; if ({busy, done, b_full, a_full} !== 11'd0) begin errors++; $display("FAIL reset_flags got %b expected 0", {busy, done, b_full, a_full}); end
    checks++; if (c_data !== '0) begin errors++; $display("FAIL reset_cdata got %h expected 0", c_data); end
    checks++; if ({dbg_state2, busy2, done2, b_full2, a_full2} !== 10'd0) begin errors++; $display("FAIL reset_dut2 got %b expected 0", {dbg_state2, busy2, done2, b_full2, a_full2}); end
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    sm = 1'b0;
    for (int r = 0; r < 8; r++) for (int k = 0; k < 8; k++) A[r][k] = (r == k) ? 8'd1 : 8'd0;
    for (int k = 0; k < 8; k++) B[k] = 8'(k + 1);
    load(1'b1, 1'b1);
    checks++; if ({a_full, b_full} !== 9'h1FF) begin errors++; $display("FAIL identity_full got %b expected all ones", {a_full, b_full}); end
    run(lat, bc, st1);
    checks++; if (st1 !== 1) begin errors++; $display("FAIL identity_clr got %0d expected 1", st1); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL identity_latency got %0d expected 17", lat); end
    checks++; if (bc !== 16) begin errors++; $display("FAIL identity_busy_cycles got %0d expected 16", bc); end
    checks++; if ({busy, a_full, b_full} !== 10'd0) begin errors++; $display("FAIL identity_empty got %b expected 0", {busy, a_full, b_full}); end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (c_data[r*19 +: 19] !== 19'(r + 1)) begin errors++; $display("FAIL identity_row%0d got %0d expected %0d", r, c_data[r*19 +: 19], r + 1); end
    end
  endtask

  task automatic test_max();
    for (int r = 0; r < 8; r++) for (int k = 0; k < 8; k++) A[r][k] = 8'hFF;
    for (int k = 0; k < 8; k++) B[k] = 8'hFF;
    load(1'b1, 1'b1);
    run(lat, bc, st1);
    checks++; if (lat !== 17) begin errors++; $display("FAIL max_latency got %0d expected 17", lat); end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (c_data[r*19 +: 19] !== 19'd520200) begin errors++; $display("FAIL max_row%0d got %0d expected 520200", r, c_data[r*19 +: 19]); end
    end
  endtask

  task automatic test_signed();
    sm = 1'b1;
    for (int r = 0; r < 8; r++) for (int k = 0; k < 8; k++) A[r][k] = 8'hFF;
    for (int k = 0; k < 8; k++) B[k] = 8'(k + 1);
    load(1'b1, 1'b1);
    run(lat, bc, st1);
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (c_data[r*19 +: 19] !== 19'h7FFDC) begin errors++; $display("FAIL signed_neg_row%0d got %h expected 7ffdc", r, c_data[r*19 +: 19]); end
    end
    for (int r = 0; r < 8; r++) for (int k = 0; k < 8; k++) A[r][k] = 8'h80;
    for (int k = 0; k < 8; k++) B[k] = 8'h80;
    load(1'b1, 1'b1);
    run(lat, bc, st1);
    checks++; if (lat !== 17) begin errors++; $display("FAIL signed_latency got %0d expected 17", lat); end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (c_data[r*19 +: 19] !== 19'd131072) begin errors++; $display("FAIL signed_min_row%0d got %0d expected 131072", r, c_data[r*19 +: 19]); end
    end
    sm = 1'b0;
  endtask

  task automatic test_gating();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 8; r++) for (int k = 0; k < 8; k++) A[r][k] = 8'd2;
    for (int k = 0; k < 8; k++) B[k] = 8'd3;
    load(1'b1, 1'b0);
    checks++; if ({a_full, b_full} !== 9'h1FE) begin errors++; $display("FAIL gate_flags got %b expected 111111110", {a_full, b_full}); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL gate_no_b got %0d expected 0", dbg_state); end
    for (int k = 0; k < 8; k++) begin
      b_wren = 1'b1;
      b_data = B[k];
      @(negedge clk);
      if (k == 6) begin
        checks++; if (b_full !== 1'b0) begin errors++; $display("FAIL gate_b_early got %b expected 0", b_full); end
      end
    end
    b_wren = 1'b0;
    checks++; if (b_full !== 1'b1) begin errors++; $display("FAIL gate_b_full got %b expected 1", b_full); end
    repeat (4) @(negedge clk);
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL gate_no_start got %0d expected 0", dbg_state); end
    a_wren = 8'h01;
    a_data[7:0] = 8'hFF;
    @(negedge clk);
    a_wren = '0;
    run(lat, bc, st1);
    checks++; if (lat !== 17) begin errors++; $display("FAIL gate_latency got %0d expected 17", lat); end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (c_data[r*19 +: 19] !== 19'd48) begin errors++; $display("FAIL gate_row%0d got %0d expected 48", r, c_data[r*19 +: 19]); end
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 8; r++) for (int k = 0; k < 8; k++) A[r][k] = (r == k) ? 8'd1 : 8'd0;
    for (int k = 0; k < 8; k++) B[k] = 8'(8 - k);
    load(1'b1, 1'b1);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rerun_done_hold got %b expected 1", done); end
    run(lat, bc, st1);
    checks++; if (st1 !== 1) begin errors++; $display("FAIL rerun_clr got %0d expected 1", st1); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL rerun_latency got %0d expected 17", lat); end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (c_data[r*19 +: 19] !== 19'(8 - r)) begin errors++; $display("FAIL rerun_row%0d got %0d expected %0d", r, c_data[r*19 +: 19], 8 - r); end
    end
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 8; r++) for (int k = 0; k < 8; k++) A[r][k] = 8'd1;
    for (int k = 0; k < 8; k++) B[k] = 8'(k + 1);
    load(1'b1, 1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dbg_state !== 3'd2) begin errors++; $display("FAIL mid_exec_state got %0d expected 2", dbg_state); end
    checks++; if (c_data[18:0] !== 19'd3) begin errors++; $display("FAIL mid_exec_row0 got %0d expected 3", c_data[18:0]); end
    rst_n = 1'b0;
    #1;
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL mid_reset_state got %0d expected 0", dbg_state); end
    checks++; if (c_data !== '0) begin errors++; $display("FAIL mid_reset_cdata got %h expected 0", c_data); end
    checks++; if ({busy, done, a_full, b_full} !== 11'd0) begin errors++; $display("FAIL mid_reset_flags got %b expected 0", {busy, done, a_full, b_full}); end
    @(negedge clk);
    rst_n = 1'b1;
    load(1'b1, 1'b1);
    run(lat, bc, st1);
    checks++; if (lat !== 17) begin errors++; $display("FAIL mid_rerun_latency got %0d expected 17", lat); end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (c_data[r*19 +: 19] !== 19'd36) begin errors++; $display("FAIL mid_rerun_row%0d got %0d expected 36", r, c_data[r*19 +: 19]); end
    end
  endtask

  task automatic test_params();
    int l2, b2;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      a_wren2 = 4'hF;
      a_data2 = 16'hFFFF;
      b_wren2 = 1'b1;
      b_data2 = 4'hF;
    end
    @(negedge clk);
    a_wren2 = '0;
    b_wren2 = 1'b0;
    checks++; if ({a_full2, b_full2} !== 5'h1F) begin errors++; $display("FAIL p2_full got %b expected 11111", {a_full2, b_full2}); end
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    l2 = -1;
    b2 = 0;
    for (int k = 1; k <= 60; k++) begin
      if (done2) begin
        l2 = k;
        break;
      end
      if (busy2) b2++;
      @(negedge clk);
    end
    checks++; if (l2 !== 21) begin errors++; $display("FAIL p2_latency got %0d expected 21", l2); end
    checks++; if (b2 !== 20) begin errors++; $display("FAIL p2_busy_cycles got %0d expected 20", b2); end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (c_data2[r*12 +: 12] !== 12'd3600) begin errors++; $display("FAIL p2_row%0d got %0d expected 3600", r, c_data2[r*12 +: 12]); end
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_max();
    test_signed();
    test_gating();
    test_back_to_back();
    test_reset_mid();
    test_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
